// File: rtl/jt12_eg_pkg.sv
// Shared definitions for the envelope-phase tracker: phase encoding, the sustain limit
// and the reset value of a stored slot entry.
package jt12_eg_pkg;

    typedef logic [1:0] eg_state_t;

    localparam eg_state_t EG_ATTACK  = 2'd0;
    localparam eg_state_t EG_DECAY   = 2'd1;
    localparam eg_state_t EG_SUSTAIN = 2'd2;
    localparam eg_state_t EG_RELEASE = 2'd3;

    localparam logic [4:0] EG_SL_MAX = 5'h1F;

    // A stored entry is {phase, previous key-on level}; reset leaves every slot released and keyed off.
    localparam logic [2:0] EG_ENTRY_RST = {EG_RELEASE, 1'b0};

    // Sustain level 15 maps to the very bottom of the attenuation range, not to 15.
    function automatic logic [4:0] sl_threshold(input logic [3:0] sl);
        return (sl == 4'hF) ? EG_SL_MAX : {1'b0, sl};
    endfunction

endpackage

// File: rtl/jt12_sh_rst.sv
// Circulating shift register with a synchronous reset value; din enters stage 0 and
// drop is the last stage, so a word reappears at drop after 'stages' clk_en cycles.
module jt12_sh_rst #(
    parameter int                 width  = 5,
    parameter int                 stages = 32,
    parameter logic [width-1:0]   rstval = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [width-1:0] din,
    output logic [width-1:0] drop
);

    logic [width-1:0] bits [stages];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < stages; i++) begin
                bits[i] <= rstval;
            end
        end else if (clk_en) begin
            bits[0] <= din;
            for (int i = 1; i < stages; i++) begin
                bits[i] <= bits[i-1];
            end
        end
    end

    assign drop = bits[stages-1];

endmodule

// File: rtl/jt12_eg_state.sv
// Per-slot ADSR phase tracker fed by the serial key-on stream; one slot per clk_en.
// Optional build macro JT12_EG_SLOT_CNT_EN adds the slot_cnt debug/alignment output.
module jt12_eg_state
    import jt12_eg_pkg::*;
#(
    parameter int num_ch = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       keyon_I,
    input  logic [9:0] eg_in,
    input  logic [3:0] sl,
    output eg_state_t  state_out,
    output logic       keyon_now,
    output logic       keyoff_now,
    output logic       pg_rst
`ifdef JT12_EG_SLOT_CNT_EN
    ,
    output logic [4:0] slot_cnt
`endif
);

    localparam int S = 4 * num_ch;

    logic [2:0] tail;
    logic [2:0] head;
    eg_state_t  cur_state;
    eg_state_t  next_state;
    logic       kon_prev;
    logic       kon_edge;
    logic       koff_edge;

    // The tail entry always belongs to the slot currently on keyon_I/eg_in/sl.
    jt12_sh_rst #(
        .width  (3),
        .stages (S),
        .rstval (EG_ENTRY_RST)
    ) u_store (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .din    (head),
        .drop   (tail)
    );

    assign cur_state = tail[2:1];
    assign kon_prev  = tail[0];

    always_comb begin
        kon_edge  = keyon_I & ~kon_prev;
        koff_edge = ~keyon_I & kon_prev;
    end

    // Edges take priority over the level-driven attack/decay exits.
    always_comb begin
        next_state = cur_state;
        if (kon_edge) begin
            next_state = EG_ATTACK;
        end else if (koff_edge) begin
            next_state = EG_RELEASE;
        end else begin
            case (cur_state)
                EG_ATTACK: if (eg_in == 10'd0) next_state = EG_DECAY;
                EG_DECAY:  if (eg_in[9:5] >= sl_threshold(sl)) next_state = EG_SUSTAIN;
                default:   next_state = cur_state;
            endcase
        end
    end

    assign head = {next_state, keyon_I};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_out  <= EG_RELEASE;
            keyon_now  <= 1'b0;
            keyoff_now <= 1'b0;
            pg_rst     <= 1'b0;
        end else if (clk_en) begin
            state_out  <= next_state;
            keyon_now  <= kon_edge;
            keyoff_now <= koff_edge;
            pg_rst     <= kon_edge;
        end
    end

`ifdef JT12_EG_SLOT_CNT_EN
    localparam logic [4:0] LAST_SLOT = 5'(S - 1);

    // in_cnt tracks the slot on the inputs; slot_cnt lags it by one like the other outputs.
    logic [4:0] in_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt   <= 5'd0;
            slot_cnt <= 5'd0;
        end else if (clk_en) begin
            in_cnt   <= (in_cnt == LAST_SLOT) ? 5'd0 : in_cnt + 5'd1;
            slot_cnt <= in_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_jt12_eg_state.sv
// Self-checking bench for jt12_eg_state: per-slot phase model in plain arrays,
// directed visits for the documented cases, then randomized traffic and a mid-stream reset.
module tb_jt12_eg_state;

    localparam int S = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       keyon_I = 1'b0;
    logic [9:0] eg_in = 10'd0;
    logic [3:0] sl = 4'd0;
    logic [1:0] state_out;
    logic       keyon_now;
    logic       keyoff_now;
    logic       pg_rst;
`ifdef JT12_EG_SLOT_CNT_EN
    logic [4:0] slot_cnt;
`endif

    jt12_eg_state #(.num_ch(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .keyon_I    (keyon_I),
        .eg_in      (eg_in),
        .sl         (sl),
        .state_out  (state_out),
        .keyon_now  (keyon_now),
        .keyoff_now (keyoff_now),
        .pg_rst     (pg_rst)
`ifdef JT12_EG_SLOT_CNT_EN
        ,
        .slot_cnt   (slot_cnt)
`endif
    );

    // clock/reset block
    always #5 clk = ~clk;

    // behavioural model: phase and last key level per slot, plus expected registered outputs
    int phase [S];
    int kprev [S];
    int cur_slot;
    int exp_state, exp_kon, exp_koff, exp_cnt;
    bit chk_on = 1'b0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            phase[i] = 3;
            kprev[i] = 0;
        end
        cur_slot  = 0;
        exp_state = 3;
        exp_kon   = 0;
        exp_koff  = 0;
        exp_cnt   = 0;
    endtask

    task automatic model_step(input int kon, input int eg, input int slv);
        int s, thr, ns;
        bit on_edge, off_edge;
        s = cur_slot;
        on_edge  = (kon == 1) && (kprev[s] == 0);
        off_edge = (kon == 0) && (kprev[s] == 1);
        thr = (slv == 15) ? 31 : slv;
        if (on_edge) ns = 0;
        else if (off_edge) ns = 3;
        else if (phase[s] == 0 && eg == 0) ns = 1;
        else if (phase[s] == 1 && (eg / 32) >= thr) ns = 2;
        else ns = phase[s];
        phase[s]  = ns;
        kprev[s]  = kon;
        exp_state = ns;
        exp_kon   = on_edge ? 1 : 0;
        exp_koff  = off_edge ? 1 : 0;
        exp_cnt   = s;
        cur_slot  = (s + 1) % S;
    endtask

    // compare process: outputs are stable at the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("state_out", 32'(state_out), 32'(exp_state));
            check("keyon_now", 32'(keyon_now), 32'(exp_kon));
            check("keyoff_now", 32'(keyoff_now), 32'(exp_koff));
            check("pg_rst", 32'(pg_rst), 32'(exp_kon));
`ifdef JT12_EG_SLOT_CNT_EN
            check("slot_cnt", 32'(slot_cnt), 32'(exp_cnt));
`endif
        end
    end

    // driver tasks: entered and left at a falling edge
    task automatic do_cycle(input bit en, input bit kon, input logic [9:0] eg, input logic [3:0] slv);
        clk_en  = en;
        keyon_I = kon;
        eg_in   = eg;
        sl      = slv;
        @(posedge clk);
        if (en) model_step(int'(kon), int'(eg), int'(slv));
        @(negedge clk);
    endtask

    task automatic do_reset(input bit kon);
        rst     = 1'b1;
        clk_en  = 1'($urandom_range(0, 1));
        keyon_I = kon;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // advance with held keys (no edges) until the given slot is on the inputs
    task automatic run_to(input int slot);
        while (cur_slot != slot) begin
            do_cycle(1'b1, 1'(kprev[cur_slot]), 10'($urandom_range(1, 1023)), 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic visit(input int slot, input bit kon, input logic [9:0] eg, input logic [3:0] slv);
        run_to(slot);
        do_cycle(1'b1, kon, eg, slv);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(1'b0);
        chk_on = 1'b1;
        check("reset_state", 32'(state_out), 32'd3);
        check("reset_pg_rst", 32'(pg_rst), 32'd0);

        for (int i = 0; i < 48; i++) begin
            do_cycle(1'b1, 1'b0, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
            check("idle_state", 32'(state_out), 32'd3);
            check("idle_keyon", 32'(keyon_now), 32'd0);
        end

        // slot 5: key-on, held key, attack completion, decay to sustain
        visit(5, 1'b1, 10'h3FF, 4'd0);
        check("s5_keyon", 32'(keyon_now), 32'd1);
        check("s5_pg_rst", 32'(pg_rst), 32'd1);
        check("s5_attack", 32'(state_out), 32'd0);
        visit(5, 1'b1, 10'h3FF, 4'd0);
        check("s5_hold_attack", 32'(state_out), 32'd0);
        check("s5_no_retrigger", 32'(keyon_now), 32'd0);
        visit(5, 1'b1, 10'h000, 4'd0);
        check("s5_decay", 32'(state_out), 32'd1);
        visit(5, 1'b1, 10'h07F, 4'd4);
        check("s5_stay_decay", 32'(state_out), 32'd1);
        visit(5, 1'b1, 10'h080, 4'd4);
        check("s5_sustain", 32'(state_out), 32'd2);

        // slot 9: sl=15 needs the very bottom of the range
        visit(9, 1'b1, 10'h3FF, 4'd0);
        visit(9, 1'b1, 10'h000, 4'd0);
        check("s9_decay", 32'(state_out), 32'd1);
        visit(9, 1'b1, 10'h3DF, 4'd15);
        check("s9_sl15_hold", 32'(state_out), 32'd1);
        visit(9, 1'b1, 10'h3E0, 4'd15);
        check("s9_sl15_sustain", 32'(state_out), 32'd2);

        // slot 7: sustain, key-off, then key-on beats attack completion
        visit(7, 1'b1, 10'h3FF, 4'd0);
        visit(7, 1'b1, 10'h000, 4'd0);
        visit(7, 1'b1, 10'h3FF, 4'd0);
        check("s7_sustain", 32'(state_out), 32'd2);
        visit(7, 1'b0, 10'h100, 4'd0);
        check("s7_keyoff", 32'(keyoff_now), 32'd1);
        check("s7_release", 32'(state_out), 32'd3);
        visit(7, 1'b1, 10'h000, 4'd0);
        check("s7_keyon", 32'(keyon_now), 32'd1);
        check("s7_keyon_wins", 32'(state_out), 32'd0);

        // a clk_en gap must hold everything
        do_cycle(1'b0, 1'b1, 10'h000, 4'd0);
        check("gap_hold_keyon", 32'(keyon_now), 32'd1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit en, kon;
            logic [9:0] eg;
            logic [3:0] slv;
            en  = ($urandom_range(0, 3) != 0);
            kon = ($urandom_range(0, 3) == 0) ? ~1'(kprev[cur_slot]) : 1'(kprev[cur_slot]);
            slv = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       eg = 10'd0;
                1:       eg = {slv[3:0] == 4'hF ? 5'h1F : {1'b0, slv}, 5'($urandom_range(0, 31))} - 10'($urandom_range(0, 1) * 32);
                default: eg = 10'($urandom_range(0, 1023));
            endcase
            do_cycle(en, kon, eg, slv);
        end

        // reset mid-stream with keys held high
        for (int i = 0; i < 7; i++) begin
            do_cycle(1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
        end
        do_reset(1'b1);
        check("mid_reset_state", 32'(state_out), 32'd3);
        for (int i = 0; i < S; i++) begin
            do_cycle(1'b1, 1'b1, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
            check("post_rst_keyon", 32'(keyon_now), 32'd1);
            check("post_rst_attack", 32'(state_out), 32'd0);
`ifdef JT12_EG_SLOT_CNT_EN
            check("post_rst_slot_cnt", 32'(slot_cnt), 32'(i));
`endif
        end
        do_cycle(1'b1, 1'b1, 10'h3FF, 4'd0);
        check("post_rst_held", 32'(keyon_now), 32'd0);
`ifdef JT12_EG_SLOT_CNT_EN
        check("slot_cnt_wrap", 32'(slot_cnt), 32'd0);
`endif
        for (int i = 0; i < S; i++) begin
            do_cycle(1'b1, 1'b1, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
